fpu_env_store: RTL and testbench
================================

// Module: fpu_env_store
// PURPOSE
//  Store-side counterpart of the FPU control word register: executes FSTCW, FSTSW and FSTENV.
//  Snapshots the control, status and tag words plus the exception pointers on start.
//  Writes them to memory as 16-bit words over a req/ack bus.
//  For FSTENV, afterwards writes the control word back with all six exception masks set
//  (8087 semantics), through the control word register's write interface.
// PARAMETERS
//  ADDR_WIDTH  20  memory byte-address width (8086 real mode)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-high reset
//  start          in   1   one-cycle request; sampled only while idle
//  op             in   2   00=FSTCW 01=FSTSW 10=FSTENV 11=illegal
//  base_addr      in   AW  destination byte address (word 0)
//  control_word   in   16  current control word
//  status_word    in   16  current status word
//  tag_word       in   16  current tag word
//  instr_ptr      in   20  last FPU instruction address
//  opcode         in   11  last FPU opcode
//  operand_ptr    in   20  last memory-operand address
//  mem_addr       out  AW  write byte address
//  mem_data       out  16  write data
//  mem_wr_req     out  1   write request, held until mem_ack
//  mem_ack        in   1   write accepted this cycle
//  cw_write_en    out  1   one-cycle write strobe to control word register
//  cw_write_data  out  16  control word | 16'h003F
//  busy           out  1   high from cycle after accepted start until done
//  done           out  1   one-cycle completion pulse
//  error          out  1   one-cycle pulse with done for op=11
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 (mem_addr, mem_data, cw_write_data included).
//  - IDLE:
//    - start=1 with op 00/01/10: latch all inputs into snapshot regs; word index=0;
//      next state WRITE; busy=1.
//    - op=11 with start: next cycle done=1, error=1, no memory write; return to IDLE.
//  - Word sequence:
//    - FSTCW: 1 word, CW.
//    - FSTSW: 1 word, SW.
//    - FSTENV: 7 words, in order:
//      - CW
//      - SW
//      - TW
//      - IP[15:0]
//      - {IP[19:16],1'b0,opcode[10:0]}
//      - OP[15:0]
//      - {OP[19:16],12'h000}
//  - WRITE:
//    - mem_wr_req=1.
//    - mem_addr = base + 2*index (mod 2^AW, wraps silently).
//    - mem_data = snapshot word[index].
//    - Address and data are stable while req is high and unacked.
//    - On mem_ack: if index = last, go to FINISH (FSTCW/FSTSW) or MASK (FSTENV);
//      otherwise index++ and stay in WRITE.
//    - The next word's request is presented the very next cycle (req stays high).
//  - mem_ack while mem_wr_req=0 is ignored.
//  - MASK: one cycle, cw_write_en=1, cw_write_data = snapshot CW | 16'h003F; go to FINISH.
//  - FINISH: done=1 for one cycle, busy=0, mem_wr_req=0; next state IDLE.
//    - A new start may be accepted in the cycle after done.
//  - start while busy or in FINISH: ignored, no queueing.
//  - Latency with zero-wait ack (ack in first req cycle):
//    - FSTCW: start@0, req@1, done@2.
//    - FSTENV: reqs @1..7, cw_write_en@8, done@9.
//  - Snapshot isolation: input changes after the start cycle do not affect stored data;
//    CW change during the store does not alter the MASK write.
//  - Reset mid-operation: abort immediately, outputs to 0, no cw_write_en, no done.
// TESTING
//  - FSTCW, CW=16'h037F, base=20'h01000, ack in first req cycle ->
//    one write addr 01000 data 037F; done at cycle 2; no cw_write_en.
//  - FSTENV, CW=0372, SW=4100, TW=FFFF, IP=ABCDE, opc=5D9, OP=12345, base=FFFFC ->
//    writes in order:
//      - FFFFC:0372
//      - FFFFE:4100
//      - 00000:FFFF (address wrap)
//      - 00002:BCDE
//      - 00004:A5D9
//      - 00006:2345
//      - 00008:1000
//    then cw_write_data=037F; done.
//  - FSTSW with ack delayed 3 cycles -> req, addr and data held constant 3 cycles;
//    done 1 cycle after ack; busy high throughout.
//  - start pulsed again mid-FSTENV, and control_word changed mid-store ->
//    second start ignored; stored and masked values use the snapshot.
//  - op=11 -> done and error together one cycle after start; mem_wr_req never asserted.
//  - Reset asserted during word 3 of FSTENV -> all outputs 0 immediately;
//    no further writes; no cw_write_en; next start works normally.

Source files
------------

// File: rtl/fpu_env_store_if.sv
// fpu_env_store_if: memory write bus (req/ack) between the FPU store unit and memory
interface fpu_env_store_if #(parameter int ADDR_WIDTH = 20);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [15:0] mem_data;
    logic mem_wr_req;
    logic mem_ack;
    modport master(output mem_addr, output mem_data, output mem_wr_req, input mem_ack);
    modport slave(input mem_addr, input mem_data, input mem_wr_req, output mem_ack);
endinterface

// File: rtl/fpu_env_store.sv
// fpu_env_store: FSTCW/FSTSW/FSTENV store sequencer with post-FSTENV exception masking
module fpu_env_store #(parameter int ADDR_WIDTH = 20) (
    input logic clk,
    input logic reset,
    input logic start,
    input logic [1:0] op,
    input logic [ADDR_WIDTH-1:0] base_addr,
    input logic [15:0] control_word,
    input logic [15:0] status_word,
    input logic [15:0] tag_word,
    input logic [19:0] instr_ptr,
    input logic [10:0] opcode,
    input logic [19:0] operand_ptr,
    fpu_env_store_if.master mem,
    output logic cw_write_en,
    output logic [15:0] cw_write_data,
    output logic busy,
    output logic done,
    output logic error
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] MASK = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;
    logic [1:0] state;
    logic [2:0] idx;
    logic env_q, err_q;
    logic [15:0] w0_q, sw_q, tw_q;
    logic [19:0] ip_q, opp_q;
    logic [10:0] opc_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [15:0] w [8];
    logic wr;
    // word 0 holds SW for FSTSW, CW otherwise, so the single-word ops share one path
    assign w = '{w0_q, sw_q, tw_q, ip_q[15:0], {ip_q[19:16], 1'b0, opc_q}, opp_q[15:0],
                 {opp_q[19:16], 12'h000}, 16'h0000};
    assign wr = state == WRITE;
    assign mem.mem_wr_req = wr;
    assign mem.mem_addr = wr ? base_q + ADDR_WIDTH'({idx, 1'b0}) : '0;
    assign mem.mem_data = wr ? w[idx] : 16'h0000;
    assign cw_write_en = state == MASK;
    assign cw_write_data = state == MASK ? w0_q | 16'h003F : 16'h0000;
    assign busy = wr || state == MASK;
    assign done = state == FINISH;
    assign error = state == FINISH && err_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            env_q <= 1'b0;
            err_q <= 1'b0;
            w0_q <= '0;
            sw_q <= '0;
            tw_q <= '0;
            ip_q <= '0;
            opp_q <= '0;
            opc_q <= '0;
            base_q <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state <= op == 2'b11 ? FINISH : WRITE;
                    err_q <= op == 2'b11;
                    env_q <= op == 2'b10;
                    idx <= '0;
                    w0_q <= op == 2'b01 ? status_word : control_word;
                    sw_q <= status_word;
                    tw_q <= tag_word;
                    ip_q <= instr_ptr;
                    opc_q <= opcode;
                    opp_q <= operand_ptr;
                    base_q <= base_addr;
                end
                WRITE: if (mem.mem_ack) begin
                    if (idx == (env_q ? 3'd6 : 3'd0)) state <= env_q ? MASK : FINISH;
                    else idx <= idx + 3'd1;
                end
                MASK: state <= FINISH;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_env_store.sv
// tb_fpu_env_store: directed checks of FSTCW/FSTSW/FSTENV sequencing, wrap, snapshot and reset abort
module tb_fpu_env_store;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [19:0] base_addr = '0;
    logic [15:0] control_word = '0, status_word = '0, tag_word = '0;
    logic [19:0] instr_ptr = '0, operand_ptr = '0;
    logic [10:0] opcode = '0;
    logic cw_write_en, busy, done, error;
    logic [15:0] cw_write_data;
    int total = 0;
    int bad = 0;
    fpu_env_store_if #(.ADDR_WIDTH(20)) bus ();
    fpu_env_store #(.ADDR_WIDTH(20)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .base_addr(base_addr),
        .control_word(control_word), .status_word(status_word), .tag_word(tag_word),
        .instr_ptr(instr_ptr), .opcode(opcode), .operand_ptr(operand_ptr), .mem(bus.master),
        .cw_write_en(cw_write_en), .cw_write_data(cw_write_data), .busy(busy), .done(done),
        .error(error)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk_quiet(input string tag);
        chk({tag, "_req"}, bus.mem_wr_req, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_data"}, bus.mem_data, 0);
        chk({tag, "_cwen"}, cw_write_en, 0);
        chk({tag, "_cwd"}, cw_write_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, error, 0);
    endtask
    logic [19:0] ea [7] = '{20'hFFFFC, 20'hFFFFE, 20'h00000, 20'h00002, 20'h00004, 20'h00006, 20'h00008};
    logic [15:0] ed [7] = '{16'h0372, 16'h4100, 16'hFFFF, 16'hBCDE, 16'hA5D9, 16'h2345, 16'h1000};
    initial begin
        bus.mem_ack = 1'b0;
        step;
        chk_quiet("rst");
        step;
        reset = 1'b0;
        // FSTCW, zero-wait ack
        start = 1'b1; op = 2'b00; control_word = 16'h037F; base_addr = 20'h01000;
        step;
        start = 1'b0;
        chk("cw_req", bus.mem_wr_req, 1);
        chk("cw_addr", bus.mem_addr, 20'h01000);
        chk("cw_data", bus.mem_data, 16'h037F);
        chk("cw_busy", busy, 1);
        chk("cw_done1", done, 0);
        chk("cw_cwen1", cw_write_en, 0);
        bus.mem_ack = 1'b1;
        step;
        bus.mem_ack = 1'b0;
        chk("cw_done", done, 1);
        chk("cw_err", error, 0);
        chk("cw_req2", bus.mem_wr_req, 0);
        chk("cw_busy2", busy, 0);
        chk("cw_cwen2", cw_write_en, 0);
        step;
        chk("cw_done_pulse", done, 0);
        // stray ack while idle must not start anything
        bus.mem_ack = 1'b1;
        step;
        bus.mem_ack = 1'b0;
        chk_quiet("idle_ack");
        // FSTENV with wrap, mid-store restart and CW change
        start = 1'b1; op = 2'b10; base_addr = 20'hFFFFC;
        control_word = 16'h0372; status_word = 16'h4100; tag_word = 16'hFFFF;
        instr_ptr = 20'hABCDE; opcode = 11'h5D9; operand_ptr = 20'h12345;
        step;
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (i == 2) begin start = 1'b1; op = 2'b00; control_word = 16'hFFFF; status_word = 16'h0; end
            if (i == 3) start = 1'b0;
            chk($sformatf("env_req%0d", i), bus.mem_wr_req, 1);
            chk($sformatf("env_addr%0d", i), bus.mem_addr, ea[i]);
            chk($sformatf("env_data%0d", i), bus.mem_data, ed[i]);
            chk($sformatf("env_busy%0d", i), busy, 1);
            chk($sformatf("env_cwen%0d", i), cw_write_en, 0);
            bus.mem_ack = 1'b1;
            step;
        end
        bus.mem_ack = 1'b0;
        chk("env_mask_en", cw_write_en, 1);
        chk("env_mask_data", cw_write_data, 16'h037F);
        chk("env_mask_req", bus.mem_wr_req, 0);
        chk("env_mask_busy", busy, 1);
        chk("env_mask_done", done, 0);
        step;
        chk("env_done", done, 1);
        chk("env_cwen_off", cw_write_en, 0);
        chk("env_busy_off", busy, 0);
        step;
        chk_quiet("env_after");
        // FSTSW with ack delayed three cycles
        start = 1'b1; op = 2'b01; status_word = 16'h3800; control_word = 16'h1111; base_addr = 20'h00200;
        step;
        start = 1'b0;
        status_word = 16'hDEAD;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sw_req%0d", i), bus.mem_wr_req, 1);
            chk($sformatf("sw_addr%0d", i), bus.mem_addr, 20'h00200);
            chk($sformatf("sw_data%0d", i), bus.mem_data, 16'h3800);
            chk($sformatf("sw_busy%0d", i), busy, 1);
            if (i == 3) bus.mem_ack = 1'b1;
            step;
        end
        bus.mem_ack = 1'b0;
        chk("sw_done", done, 1);
        chk("sw_req_off", bus.mem_wr_req, 0);
        chk("sw_cwen", cw_write_en, 0);
        step;
        // illegal op
        start = 1'b1; op = 2'b11;
        step;
        start = 1'b0;
        chk("ill_done", done, 1);
        chk("ill_err", error, 1);
        chk("ill_req", bus.mem_wr_req, 0);
        chk("ill_busy", busy, 0);
        step;
        chk_quiet("ill_after");
        // reset while word 3 of FSTENV is on the bus
        start = 1'b1; op = 2'b10; base_addr = 20'h00100; control_word = 16'h0372;
        step;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ack = 1'b1;
            step;
        end
        bus.mem_ack = 1'b0;
        chk("rm_addr3", bus.mem_addr, 20'h00106);
        reset = 1'b1;
        #1;
        chk_quiet("rm_abort");
        step;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            chk_quiet($sformatf("rm_idle%0d", i));
        end
        start = 1'b1; op = 2'b00; control_word = 16'h027F; base_addr = 20'h00300;
        step;
        start = 1'b0;
        chk("rm_cw_addr", bus.mem_addr, 20'h00300);
        chk("rm_cw_data", bus.mem_data, 16'h027F);
        bus.mem_ack = 1'b1;
        step;
        bus.mem_ack = 1'b0;
        chk("rm_cw_done", done, 1);
        step;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
